// File: rtl/acc_calc_pkg.sv
// Shared definitions for the accumulator calculator: widths, opcodes, FSM states.
package acc_calc_pkg;

  localparam int unsigned W    = 16;
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_ABSA = 3'b010;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b011;
  localparam logic [OP_W-1:0] OP_RSUB = 3'b100;
  localparam logic [OP_W-1:0] OP_ABSD = 3'b101;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b110;
  localparam logic [OP_W-1:0] OP_READ = 3'b111;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/acc_calc_if.sv
// Command/response bus between a host sequencer (master) and acc_calc (slave).
interface acc_calc_if;
  import acc_calc_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [W-1:0]    cmd_data;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_data;
  logic            res_ovf;
  logic            sticky_ovf;
  logic [W-1:0]    acc;

  modport master (
    output cmd_valid, cmd_op, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_ovf, sticky_ovf, acc
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_ovf, sticky_ovf, acc
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational signed ALU: one shared adder/subtractor fed by an operand-swap mux.
module calc_alu
  import acc_calc_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [W-1:0]    r,
  output logic            ovf
);

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] y_eff;
  logic [W-1:0] sum;
  logic         sub;
  logic         add_ovf;

  // ABS is 0 +/- value, so it reuses the subtract path (~y + 1) when negative
  always_comb begin
    x   = '0;
    y   = '0;
    sub = 1'b0;
    unique case (op)
      OP_ADD:  begin x = a; y = b; end
      OP_SUB:  begin x = a; y = b; sub = 1'b1; end
      OP_RSUB: begin x = b; y = a; sub = 1'b1; end
      OP_ABSA: begin y = a; sub = a[W-1]; end
      OP_ABSD: begin y = b; sub = b[W-1]; end
      OP_LOAD: y = b;
      OP_READ: y = a;
      default: y = '0;
    endcase
  end

  assign y_eff   = y ^ {W{sub}};
  assign sum     = x + y_eff + W'(sub);
  assign add_ovf = (x[W-1] == y_eff[W-1]) && (sum[W-1] != x[W-1]);

  always_comb begin
    r   = sum;
    ovf = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_RSUB: ovf = add_ovf;
      OP_ABSA, OP_ABSD:        ovf = (y == MOST_NEG);
      default:                 ovf = 1'b0;
    endcase
  end

endmodule

// File: rtl/acc_calc.sv
// Accumulator calculator front end: IDLE/EXEC/RESP FSM plus ACC, result and sticky registers.
module acc_calc
  import acc_calc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  acc_calc_if.slave  bus
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    res_data_q, res_data_d;
  logic            res_ovf_q, res_ovf_d;
  logic            sticky_q, sticky_d;
  logic [W-1:0]    alu_r;
  logic            alu_ovf;

  calc_alu u_alu (
    .op  (op_q),
    .a   (acc_q),
    .b   (d_q),
    .r   (alu_r),
    .ovf (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      d_q        <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      d_q        <= d_d;
      acc_q      <= acc_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    d_d        = d_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    sticky_d   = sticky_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          d_d     = bus.cmd_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        acc_d      = alu_r;
        res_data_d = alu_r;
        res_ovf_d  = alu_ovf;
        sticky_d   = (op_q == OP_CLR) ? 1'b0 : (sticky_q | alu_ovf);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are state decodes, masked while reset is held
  assign bus.cmd_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.res_valid  = (state_q == ST_RESP) && !reset;
  assign bus.res_data   = res_data_q;
  assign bus.res_ovf    = res_ovf_q;
  assign bus.sticky_ovf = sticky_q;
  assign bus.acc        = acc_q;

endmodule

// File: tb/tb_acc_calc.sv
// Directed self-checking bench for acc_calc using hand-computed expected values.
module tb_acc_calc;
  import acc_calc_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  acc_calc_if bus ();

  acc_calc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, check EXEC gap, then check the response fields in RESP.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [15:0] data,
                        input logic [15:0] exp_r, input logic exp_ovf, input logic exp_sticky);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, " accept_timeout"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 16'hDEAD;
    check({tag, " exec_valid"}, 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check({tag, " res_valid"},  32'(bus.res_valid),  32'd1);
    check({tag, " res_data"},   32'(bus.res_data),   32'(exp_r));
    check({tag, " res_ovf"},    32'(bus.res_ovf),    32'(exp_ovf));
    check({tag, " sticky"},     32'(bus.sticky_ovf), 32'(exp_sticky));
    check({tag, " acc"},        32'(bus.acc),        32'(exp_r));
    if (bus.res_ready) begin
      @(negedge clk);
      check({tag, " ready_after"}, 32'(bus.cmd_ready), 32'd1);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 16'h0000;
    bus.res_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    check("rst cmd_ready",  32'(bus.cmd_ready),  32'd0);
    check("rst res_valid",  32'(bus.res_valid),  32'd0);
    check("rst acc",        32'(bus.acc),        32'd0);
    check("rst res_data",   32'(bus.res_data),   32'd0);
    check("rst res_ovf",    32'(bus.res_ovf),    32'd0);
    check("rst sticky",     32'(bus.sticky_ovf), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst cmd_ready", 32'(bus.cmd_ready), 32'd1);

    do_cmd("load5",   OP_LOAD, 16'h0005, 16'h0005, 1'b0, 1'b0);
    do_cmd("add3",    OP_ADD,  16'h0003, 16'h0008, 1'b0, 1'b0);
    do_cmd("load7fff",OP_LOAD, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    do_cmd("add1ovf", OP_ADD,  16'h0001, 16'h8000, 1'b1, 1'b1);
    do_cmd("add0",    OP_ADD,  16'h0000, 16'h8000, 1'b0, 1'b1);
    do_cmd("clr",     OP_CLR,  16'h1234, 16'h0000, 1'b0, 1'b0);
    do_cmd("load8000",OP_LOAD, 16'h8000, 16'h8000, 1'b0, 1'b0);
    do_cmd("absa_min",OP_ABSA, 16'h1111, 16'h8000, 1'b1, 1'b1);
    do_cmd("loadfffb",OP_LOAD, 16'hFFFB, 16'hFFFB, 1'b0, 1'b1);
    do_cmd("absa_neg",OP_ABSA, 16'h2222, 16'h0005, 1'b0, 1'b1);
    do_cmd("absd7",   OP_ABSD, 16'h0007, 16'h0007, 1'b0, 1'b1);
    do_cmd("absd_neg",OP_ABSD, 16'hFFF0, 16'h0010, 1'b0, 1'b1);
    do_cmd("load3",   OP_LOAD, 16'h0003, 16'h0003, 1'b0, 1'b1);
    do_cmd("rsub1",   OP_RSUB, 16'h0001, 16'hFFFE, 1'b0, 1'b1);
    do_cmd("sub_neg", OP_SUB,  16'h0002, 16'hFFFC, 1'b0, 1'b1);
    do_cmd("clr2",    OP_CLR,  16'h0000, 16'h0000, 1'b0, 1'b0);
    do_cmd("sub8000", OP_SUB,  16'h8000, 16'h8000, 1'b1, 1'b1);
    do_cmd("read",    OP_READ, 16'h5555, 16'h8000, 1'b0, 1'b1);
    do_cmd("add_nn",  OP_ADD,  16'hFFFF, 16'h7FFF, 1'b1, 1'b1);

    // Back-pressure: response must stay frozen and no new command may slip in
    bus.res_ready = 1'b0;
    do_cmd("bp_load", OP_LOAD, 16'h1234, 16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = (i % 2 == 0);
      bus.cmd_op    = OP_ADD;
      bus.cmd_data  = 16'h0001;
      @(negedge clk);
      check("bp res_valid",  32'(bus.res_valid), 32'd1);
      check("bp res_data",   32'(bus.res_data),  32'h1234);
      check("bp res_ovf",    32'(bus.res_ovf),   32'd0);
      check("bp cmd_ready",  32'(bus.cmd_ready), 32'd0);
      check("bp acc",        32'(bus.acc),       32'h1234);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp hs res_valid", 32'(bus.res_valid), 32'd0);
    check("bp hs cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    check("bp idle res_valid", 32'(bus.res_valid), 32'd0);
    check("bp idle acc",       32'(bus.acc),       32'h1234);

    // Reset while the command is in EXEC discards it
    do_cmd("r_load",  OP_LOAD, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("r exec_valid", 32'(bus.res_valid), 32'd0);
    reset = 1'b1;
    #1;
    check("r during cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("r res_valid",  32'(bus.res_valid),  32'd0);
    check("r acc",        32'(bus.acc),        32'd0);
    check("r sticky",     32'(bus.sticky_ovf), 32'd0);
    check("r res_data",   32'(bus.res_data),   32'd0);
    check("r cmd_ready",  32'(bus.cmd_ready),  32'd1);
    @(negedge clk);
    check("r no_resp",    32'(bus.res_valid),  32'd0);
    do_cmd("r_after", OP_ADD, 16'h0009, 16'h0009, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
